// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types.
//   word_t    - 32-bit datapath word
//   regbits_t - 5-bit register-file index
//   aluop_t   - ALU operation select
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// diaosi_types_pkg: pipeline-specific types.
//   alusrc_t    - ALU B-operand source select
//   idex_t      - contents of the ID/EX pipeline register
//   IDEX_BUBBLE - the no-op value loaded when a bubble is inserted
package diaosi_types_pkg;

  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    RDAT2_DIAOSI = 2'd0,
    EXT_DIAOSI   = 2'd1,
    NPC_DIAOSI   = 2'd2,
    LUI_DIAOSI   = 2'd3
  } alusrc_t;

  typedef struct packed {
    logic     valid;
    word_t    npc;
    word_t    rdat1;
    word_t    rdat2;
    word_t    ext;
    regbits_t rsel1;
    regbits_t rsel2;
    logic     uses_rt;
    regbits_t wsel;
    logic     wen;
    logic     dren;
    logic     dwen;
    logic     memtoreg;
    logic     halt;
    alusrc_t  alusrc;
    aluop_t   aluop;
  } idex_t;

  // A bubble has no architectural side effects: nothing written, no memory
  // access, no halt, and wsel = 0 so it can never look like a load producer.
  localparam idex_t IDEX_BUBBLE = '{
    valid:    1'b0,
    npc:      32'h0000_0000,
    rdat1:    32'h0000_0000,
    rdat2:    32'h0000_0000,
    ext:      32'h0000_0000,
    rsel1:    5'd0,
    rsel2:    5'd0,
    uses_rt:  1'b0,
    wsel:     5'd0,
    wen:      1'b0,
    dren:     1'b0,
    dwen:     1'b0,
    memtoreg: 1'b0,
    halt:     1'b0,
    alusrc:   RDAT2_DIAOSI,
    aluop:    ALU_SLL
  };

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard detection.
// A hazard exists when the instruction in EX is a valid load that writes a
// non-zero register which the valid instruction in ID reads as an operand.
//   ld_*  - fields of the instruction currently held in ID/EX
//   id_*  - fields of the instruction currently in ID
//   lu_hz - hazard present
module load_use_detect
  import cpu_types_pkg::*;
(
  input  logic     ld_valid,
  input  logic     ld_dren,
  input  logic     ld_wen,
  input  regbits_t ld_wsel,
  input  logic     id_valid,
  input  regbits_t id_rsel1,
  input  regbits_t id_rsel2,
  input  logic     id_uses_rt,
  output logic     lu_hz
);

  logic producer_s;
  logic match_s;

  // $0 is hard-wired, so a load targeting it never creates a dependency.
  assign producer_s = ld_valid & ld_dren & ld_wen & (ld_wsel != {REG_W{1'b0}});
  // rt only counts when the ID instruction actually consumes it as an operand.
  assign match_s    = (ld_wsel == id_rsel1) | (id_uses_rt & (ld_wsel == id_rsel2));
  assign lu_hz      = producer_s & id_valid & match_s;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion.
// Inputs *_i are the decoded ID fields; outputs *_o2 are their registered
// copies feeding EX and the forwarding unit. stall asks PC/IF-ID to hold;
// lu_cnt counts inserted load-use bubbles (saturating).
//   CLK, RST         - clock, asynchronous active-high reset
//   enable           - pipeline advance; low freezes every register
//   flush            - taken branch/jump: squash ID on the next advance
//   stall            - combinational ID-hold request
//   lu_cnt           - load-use bubble count
module id_ex_stage
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enable,
  input  logic             flush,
  input  logic             valid_i,
  input  word_t            npc_i,
  input  word_t            rdat1_i,
  input  word_t            rdat2_i,
  input  word_t            ext_i,
  input  regbits_t         rsel1_i,
  input  regbits_t         rsel2_i,
  input  logic             uses_rt_i,
  input  regbits_t         wsel_i,
  input  logic             wen_i,
  input  logic             dren_i,
  input  logic             dwen_i,
  input  logic             memtoreg_i,
  input  logic             halt_i,
  input  alusrc_t          ALUSrc_i,
  input  aluop_t           aluop_i,
  output logic             valid_o2,
  output word_t            npc_o2,
  output word_t            rdat1_o2,
  output word_t            rdat2_o2,
  output word_t            ext_o2,
  output regbits_t         rsel1_o2,
  output regbits_t         rsel2_o2,
  output logic             uses_rt_o2,
  output regbits_t         wsel_o2,
  output logic             wen_o2,
  output logic             dren_o2,
  output logic             dwen_o2,
  output logic             memtoreg_o2,
  output logic             halt_o2,
  output alusrc_t          ALUSrc_o2,
  output aluop_t           aluop_o2,
  output logic             stall,
  output logic [CNT_W-1:0] lu_cnt
);

  idex_t            idex_in;
  idex_t            idex_d;
  idex_t            idex_q;
  logic [CNT_W-1:0] lu_cnt_d;
  logic [CNT_W-1:0] lu_cnt_q;
  logic             lu_hz;

  assign idex_in = '{
    valid:    valid_i,
    npc:      npc_i,
    rdat1:    rdat1_i,
    rdat2:    rdat2_i,
    ext:      ext_i,
    rsel1:    rsel1_i,
    rsel2:    rsel2_i,
    uses_rt:  uses_rt_i,
    wsel:     wsel_i,
    wen:      wen_i,
    dren:     dren_i,
    dwen:     dwen_i,
    memtoreg: memtoreg_i,
    halt:     halt_i,
    alusrc:   ALUSrc_i,
    aluop:    aluop_i
  };

  load_use_detect u_load_use_detect (
    .ld_valid   (idex_q.valid),
    .ld_dren    (idex_q.dren),
    .ld_wen     (idex_q.wen),
    .ld_wsel    (idex_q.wsel),
    .id_valid   (valid_i),
    .id_rsel1   (rsel1_i),
    .id_rsel2   (rsel2_i),
    .id_uses_rt (uses_rt_i),
    .lu_hz      (lu_hz)
  );

  // A flush kills the dependent instruction, so there is nothing to hold.
  assign stall = lu_hz & ~flush;

  // Next-state: hold, squash (flush), load-use bubble, or normal advance.
  always_comb begin
    idex_d   = idex_q;
    lu_cnt_d = lu_cnt_q;
    if (enable) begin
      if (flush) begin
        // Flush wins over the hazard; the bubble is not a load-use bubble.
        idex_d = IDEX_BUBBLE;
      end else if (lu_hz) begin
        idex_d = IDEX_BUBBLE;
        if (lu_cnt_q != {CNT_W{1'b1}}) begin
          lu_cnt_d = lu_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          lu_cnt_d = lu_cnt_q;
        end
      end else begin
        idex_d = idex_in;
      end
    end else begin
      idex_d   = idex_q;
      lu_cnt_d = lu_cnt_q;
    end
  end

  // Pipeline register and bubble counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idex_q   <= IDEX_BUBBLE;
      lu_cnt_q <= {CNT_W{1'b0}};
    end else begin
      idex_q   <= idex_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  assign valid_o2    = idex_q.valid;
  assign npc_o2      = idex_q.npc;
  assign rdat1_o2    = idex_q.rdat1;
  assign rdat2_o2    = idex_q.rdat2;
  assign ext_o2      = idex_q.ext;
  assign rsel1_o2    = idex_q.rsel1;
  assign rsel2_o2    = idex_q.rsel2;
  assign uses_rt_o2  = idex_q.uses_rt;
  assign wsel_o2     = idex_q.wsel;
  assign wen_o2      = idex_q.wen;
  assign dren_o2     = idex_q.dren;
  assign dwen_o2     = idex_q.dwen;
  assign memtoreg_o2 = idex_q.memtoreg;
  assign halt_o2     = idex_q.halt;
  assign ALUSrc_o2   = idex_q.alusrc;
  assign aluop_o2    = idex_q.aluop;
  assign lu_cnt      = lu_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage with a behavioural
// reference model of the ID/EX register contents and the bubble counter.
module tb_id_ex_stage;

  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;

  // Narrow counter so saturation is reachable in a short run.
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic        valid;
    logic [31:0] npc;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [31:0] ext;
    logic [4:0]  rsel1;
    logic [4:0]  rsel2;
    logic        uses_rt;
    logic [4:0]  wsel;
    logic        wen;
    logic        dren;
    logic        dwen;
    logic        memtoreg;
    logic        halt;
    logic [1:0]  alusrc;
    logic [3:0]  aluop;
  } fld_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic enable = 1'b0;
  logic flush = 1'b0;
  fld_t in_s = '0;

  logic             valid_o2, uses_rt_o2, wen_o2, dren_o2, dwen_o2, memtoreg_o2, halt_o2;
  word_t            npc_o2, rdat1_o2, rdat2_o2, ext_o2;
  regbits_t         rsel1_o2, rsel2_o2, wsel_o2;
  alusrc_t          alusrc_o2_w;
  aluop_t           aluop_o2_w;
  logic             stall;
  logic [CNT_W-1:0] lu_cnt;
  fld_t             dut_o;

  // Reference model state: expected register contents and bubble count.
  fld_t m = '0;
  int   m_cnt = 0;

  int n_pass = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .flush(flush),
    .valid_i(in_s.valid), .npc_i(in_s.npc), .rdat1_i(in_s.rdat1),
    .rdat2_i(in_s.rdat2), .ext_i(in_s.ext), .rsel1_i(in_s.rsel1),
    .rsel2_i(in_s.rsel2), .uses_rt_i(in_s.uses_rt), .wsel_i(in_s.wsel),
    .wen_i(in_s.wen), .dren_i(in_s.dren), .dwen_i(in_s.dwen),
    .memtoreg_i(in_s.memtoreg), .halt_i(in_s.halt),
    .ALUSrc_i(alusrc_t'(in_s.alusrc)), .aluop_i(aluop_t'(in_s.aluop)),
    .valid_o2(valid_o2), .npc_o2(npc_o2), .rdat1_o2(rdat1_o2),
    .rdat2_o2(rdat2_o2), .ext_o2(ext_o2), .rsel1_o2(rsel1_o2),
    .rsel2_o2(rsel2_o2), .uses_rt_o2(uses_rt_o2), .wsel_o2(wsel_o2),
    .wen_o2(wen_o2), .dren_o2(dren_o2), .dwen_o2(dwen_o2),
    .memtoreg_o2(memtoreg_o2), .halt_o2(halt_o2),
    .ALUSrc_o2(alusrc_o2_w), .aluop_o2(aluop_o2_w),
    .stall(stall), .lu_cnt(lu_cnt)
  );

  assign dut_o = {valid_o2, npc_o2, rdat1_o2, rdat2_o2, ext_o2, rsel1_o2, rsel2_o2,
                  uses_rt_o2, wsel_o2, wen_o2, dren_o2, dwen_o2, memtoreg_o2, halt_o2,
                  alusrc_o2_w, aluop_o2_w};

  // Build a valid ID instruction with random data words.
  function automatic fld_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic urt, input logic w, input logic dr, input logic dw,
                              input logic m2r, input logic [1:0] src, input logic [3:0] op);
    fld_t f;
    f.valid = 1'b1;     f.npc = $urandom;   f.rdat1 = $urandom;
    f.rdat2 = $urandom; f.ext = $urandom;   f.rsel1 = rs;
    f.rsel2 = rt;       f.uses_rt = urt;    f.wsel = rd;
    f.wen = w;          f.dren = dr;        f.dwen = dw;
    f.memtoreg = m2r;   f.halt = 1'b0;      f.alusrc = src;
    f.aluop = op;
    return f;
  endfunction

  // Load-use rule: EX holds a real load writing a non-zero register that the
  // real ID instruction reads (rt only when it is an operand).
  function automatic bit lu_ref();
    return m.valid && m.dren && m.wen && (m.wsel != 5'd0) && in_s.valid &&
           ((m.wsel == in_s.rsel1) || (in_s.uses_rt && (m.wsel == in_s.rsel2)));
  endfunction

  // Advance one clock: model computes what the edge should capture.
  // Bubbles and reset are all-zero (RDAT2_DIAOSI and ALU_SLL are both 0).
  task automatic tick();
    bit hz;
    hz = lu_ref();
    @(posedge CLK);
    if (enable) begin
      if (flush) begin
        m = '0;
      end else if (hz) begin
        m = '0;
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end else begin
        m = in_s;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; enable = 1'b0; in_s = '0;
    repeat (2) @(posedge CLK);
    #1;
    n_total++;
    if (dut_o !== '0 || lu_cnt !== 8'd0) $display("FAIL reset_init: o2 %h cnt %0d, want 0 0", dut_o, lu_cnt);
    else n_pass++;
    RST = 1'b0;
    // Load ADDU $3,$1,$2 then reset mid-cycle.
    in_s = mk(5'd3 - 5'd2, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2);
    enable = 1'b1;
    tick();
    n_total++;
    if (valid_o2 !== 1'b1) $display("FAIL reset_preload: valid_o2 %b want 1", valid_o2);
    else n_pass++;
    #2 RST = 1'b1;
    #1;
    n_total++;
    if (dut_o !== '0 || lu_cnt !== 8'd0) $display("FAIL reset_async: o2 %h cnt %0d, want 0 0", dut_o, lu_cnt);
    else n_pass++;
    m = '0; m_cnt = 0;
    #1 RST = 1'b0;
  endtask

  task automatic test_pass_through();
    enable = 1'b1; flush = 1'b0;
    in_s = mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2);
    in_s.rdat1 = 32'h5; in_s.rdat2 = 32'h7;
    #1;
    n_total++;
    if (stall !== 1'b0) $display("FAIL pass_stall: stall %b want 0", stall);
    else n_pass++;
    tick();
    n_total++;
    if (rsel1_o2 !== 5'd1 || rsel2_o2 !== 5'd2 || wsel_o2 !== 5'd3 || rdat1_o2 !== 32'h5 ||
        rdat2_o2 !== 32'h7 || wen_o2 !== 1'b1)
      $display("FAIL pass_fields: rs %0d rt %0d rd %0d rdat1 %h wen %b, want 1 2 3 5 1",
               rsel1_o2, rsel2_o2, wsel_o2, rdat1_o2, wen_o2);
    else n_pass++;
    n_total++;
    if (dut_o !== m) $display("FAIL pass_vec: o2 %h want %h", dut_o, m);
    else n_pass++;
  endtask

  task automatic test_load_use();
    int c0;
    fld_t addu;
    enable = 1'b1; flush = 1'b0;
    in_s = mk(5'd1, 5'd4, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 4'd2); // LW $4
    tick();
    c0 = m_cnt;
    addu = mk(5'd4, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2); // ADDU $5,$4,$1
    in_s = addu;
    #1;
    n_total++;
    if (stall !== 1'b1) $display("FAIL lu_stall: stall %b want 1", stall);
    else n_pass++;
    tick();
    n_total++;
    if (wen_o2 !== 1'b0 || dut_o !== '0 || lu_cnt !== 8'(c0 + 1))
      $display("FAIL lu_bubble: o2 %h cnt %0d, want 0 %0d", dut_o, lu_cnt, c0 + 1);
    else n_pass++;
    n_total++;
    if (stall !== 1'b0) $display("FAIL lu_release: stall %b want 0", stall);
    else n_pass++;
    tick();
    n_total++;
    if (dut_o !== addu) $display("FAIL lu_enter: o2 %h want %h", dut_o, addu);
    else n_pass++;
  endtask

  task automatic test_load_use_rt();
    enable = 1'b1; flush = 1'b0;
    in_s = mk(5'd1, 5'd4, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 4'd2); // LW $4
    tick();
    in_s = mk(5'd1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 4'd2); // SW $4,0($1)
    #1;
    n_total++;
    if (stall !== 1'b1) $display("FAIL rt_store_stall: stall %b want 1", stall);
    else n_pass++;
    tick();
    tick();
    in_s = mk(5'd1, 5'd4, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 4'd2); // LW $4
    tick();
    in_s = mk(5'd2, 5'd4, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'd2); // ADDIU $6,$2,4
    #1;
    n_total++;
    if (stall !== 1'b0) $display("FAIL rt_unused_stall: stall %b want 0", stall);
    else n_pass++;
    tick();
    n_total++;
    if (dut_o !== m) $display("FAIL rt_unused_vec: o2 %h want %h", dut_o, m);
    else n_pass++;
    // Load to $0 never stalls.
    in_s = mk(5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 4'd2);
    tick();
    in_s = mk(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2);
    #1;
    n_total++;
    if (stall !== 1'b0) $display("FAIL zero_reg_stall: stall %b want 0", stall);
    else n_pass++;
    tick();
  endtask

  task automatic test_flush_priority();
    int c0;
    enable = 1'b1; flush = 1'b0;
    in_s = mk(5'd1, 5'd4, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 4'd2);
    tick();
    c0 = m_cnt;
    in_s = mk(5'd4, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2);
    flush = 1'b1;
    #1;
    n_total++;
    if (stall !== 1'b0) $display("FAIL flush_stall: stall %b want 0", stall);
    else n_pass++;
    tick();
    n_total++;
    if (dut_o !== '0 || lu_cnt !== 8'(c0))
      $display("FAIL flush_bubble: o2 %h cnt %0d, want 0 %0d", dut_o, lu_cnt, c0);
    else n_pass++;
    flush = 1'b0;
  endtask

  task automatic test_hold();
    fld_t ld;
    int c0;
    enable = 1'b1; flush = 1'b0;
    ld = mk(5'd1, 5'd4, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 4'd2);
    in_s = ld;
    tick();
    c0 = m_cnt;
    in_s = mk(5'd4, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (stall !== 1'b1) $display("FAIL hold_stall%0d: stall %b want 1", i, stall);
      else n_pass++;
      tick();
      n_total++;
      if (dut_o !== ld || lu_cnt !== 8'(c0))
        $display("FAIL hold_frozen%0d: o2 %h cnt %0d, want %h %0d", i, dut_o, lu_cnt, ld, c0);
      else n_pass++;
    end
    enable = 1'b1;
    tick();
  endtask

  task automatic test_random();
    bit exp_st;
    for (int i = 0; i < 300; i++) begin
      in_s = mk(5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                2'($urandom_range(3, 0)), 4'($urandom_range(9, 0)));
      in_s.valid = ($urandom_range(9, 0) != 0);
      in_s.halt  = ($urandom_range(19, 0) == 0);
      enable     = ($urandom_range(4, 0) != 0);
      flush      = ($urandom_range(9, 0) == 0);
      #1;
      exp_st = lu_ref() && !flush;
      n_total++;
      if (stall !== exp_st) $display("FAIL rand_stall%0d: stall %b want %b", i, stall, exp_st);
      else n_pass++;
      tick();
      n_total++;
      if (dut_o !== m || lu_cnt !== 8'(m_cnt))
        $display("FAIL rand_state%0d: o2 %h cnt %0d, want %h %0d", i, dut_o, lu_cnt, m, m_cnt);
      else n_pass++;
    end
    enable = 1'b1; flush = 1'b0;
  endtask

  task automatic test_saturation();
    // LW $4,0($4) repeated: each copy depends on the previous one, giving a
    // bubble every other cycle until the counter pins at all-ones.
    enable = 1'b1; flush = 1'b0;
    in_s = mk(5'd4, 5'd4, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 4'd2);
    for (int i = 0; i < 2 * CNT_MAX + 20; i++) begin
      tick();
      n_total++;
      if (lu_cnt !== 8'(m_cnt)) $display("FAIL sat_count%0d: cnt %0d want %0d", i, lu_cnt, m_cnt);
      else n_pass++;
    end
    n_total++;
    if (lu_cnt !== 8'hFF) $display("FAIL sat_final: cnt %h want ff", lu_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load_use();
    test_load_use_rt();
    test_flush_priority();
    test_hold();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipeline, with integrated load-use hazard detection and bubble insertion.
- Captures decoded operands and control from ID and presents the `_o2` signals consumed by the forwarding unit and the EX datapath.
- Generates the ID-stall request to PC/IF-ID.
- Counts inserted load-use bubbles for performance monitoring.

Parameters:
- CNT_W, 16, width of the saturating load-use bubble counter.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset; asynchronous, active-high.
- enable  in  1  pipeline advance; low holds all registers (cache miss / ihit low).
- flush  in  1  branch/jump resolved taken; squash ID contents on next advance.
- valid_i  in  1  ID holds a real instruction.
- npc_i  in  32  PC+4 of ID instruction.
- rdat1_i, rdat2_i  in  32 each  register-file read data.
- ext_i  in  32  extended immediate.
- rsel1_i, rsel2_i  in  5 each  source register numbers.
- uses_rt_i  in  1  instruction reads rsel2 as an operand (R-type, branch, store).
- wsel_i  in  5  destination register.
- wen_i, dren_i, dwen_i, memtoreg_i, halt_i  in  1 each  control bits.
- ALUSrc_i  in  2  ALU B-source select (package enum).
- aluop_i  in  4  aluop_t.
- valid_o2 … aluop_o2  out  same widths  registered copies of every input field above.
- stall  out  1  combinational: ID must hold this cycle.
- lu_cnt  out  CNT_W  load-use bubbles inserted.

Behaviour:
- Reset (RST high, any time, asynchronous): all `_o2` outputs = 0, including valid, wen, dren, dwen and halt. ALUSrc_o2 = RDAT2_DIAOSI. lu_cnt = 0.
- Hazard detect (combinational): `lu_hz = valid_o2 & dren_o2 & wen_o2 & (wsel_o2 != 0) & valid_i & ((wsel_o2 == rsel1_i) | (uses_rt_i & (wsel_o2 == rsel2_i)))`.
- Hazard output: `stall = lu_hz & ~flush`. A flush kills the dependent instruction, so no stall is raised.
- Rising edge with enable = 0: hold all registers, including lu_cnt. stall still reflects lu_hz.
- Rising edge with enable = 1, priority order:
  1. flush: load a bubble.
  2. lu_hz: load a bubble; lu_cnt increments, saturating at all-ones.
  3. Otherwise: load all inputs into `_o2`.
- Bubble definition: valid, wen, dren, dwen, memtoreg, halt = 0; wsel = 0; ALUSrc = RDAT2_DIAOSI; aluop = ALU_SLL; data fields = 0.
- Latency: one cycle, ID → `_o2`.
- Load-use penalty: exactly one bubble. On the next cycle the load has moved on (o2 holds the bubble), so lu_hz = 0 and the dependent instruction enters.
- halt_o2: propagates like any control bit; no stickiness here. Halt latching is owned downstream.
- wsel_i = 0 with a load: never stalls.
- Back-to-back loads with no dependency: no stall.
- Flush and lu_hz in the same cycle: exactly one bubble; lu_cnt unchanged.

Decomposition:
- Add to diaosi_types_pkg:
  - `idex_t` packed struct holding all `_o2` fields.
  - `IDEX_BUBBLE` constant.
  - ALUSrc enum reused as is.
- aluop_t and word_t/regbits_t come from cpu_types_pkg.
- Natural sub-module: `load_use_detect` (pure combinational, produces lu_hz).
- Register, bubble mux and counter stay in the top module.

Test Plan:
- Reset: assert RST mid-cycle with valid data loaded → all `_o2` = 0 and lu_cnt = 0 immediately, without waiting for a clock edge.
- Pass-through: enable = 1; ID holds ADDU $3,$1,$2 (rdat1 = 0x5, rdat2 = 0x7) → next cycle rsel1_o2 = 1, rsel2_o2 = 2, wsel_o2 = 3, rdat1_o2 = 0x5, wen_o2 = 1, stall = 0.
- Load-use: o2 holds LW $4 (dren = 1, wen = 1, wsel = 4); ID holds ADDU $5,$4,$1 → stall = 1. Next edge: o2 is a bubble (wen_o2 = 0), lu_cnt = 1. Following edge: ADDU is in o2.
- Load-use on rt: LW $4 in o2; ID holds SW $4,0($1) (uses_rt = 1, rsel2 = 4) → stall = 1. Same case with uses_rt = 0 (ADDIU $6,$2,4 with rsel2 = 4) → stall = 0.
- Flush priority: LW $4 in o2, dependent instruction in ID, flush = 1 → stall = 0, bubble loaded, lu_cnt unchanged.
- Hold and saturation: enable = 0 for 3 cycles with a hazard present → `_o2` and lu_cnt frozen, stall = 1 throughout. Preload lu_cnt = 0xFFFF, trigger a hazard → lu_cnt stays at 0xFFFF.
